// File: rtl/nvram_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nvram_backup_ctrl
// Description : Battery-NVRAM controller. A dual-port byte RAM is shared by
//               the CPU bus (0x32xxxx chip select) and the HPS backup/restore
//               port. CPU writes mark their save block dirty. After a quiet
//               interval with no CPU writes, dirty blocks are requested one at
//               a time from the HPS, lowest index first. CPU accesses are
//               stalled (no ack) while a restore is in progress.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   system clock (clk30 domain)
//   reset_n          in   asynchronous active-low reset
//   cpu_cs           in   chip select, held for the whole CPU access
//   cpu_addr         in   byte index into the RAM
//   cpu_write_strobe in   1 = write, 0 = read
//   cpu_uds          in   upper byte lane enable, gates writes
//   cpu_din          in   write data byte
//   cpu_dout         out  read data, byte replicated on both lanes
//   cpu_bus_ack      out  one acknowledge per access
//   cpu_changed      out  one-cycle pulse per committed CPU write
//   hps_addr         in   backup/restore address
//   hps_din          in   restore data
//   hps_wr           in   restore write, honoured only during restore
//   hps_dout         out  backup read data, one cycle latency
//   restore_active   in   HPS restore in progress
//   save_req         out  block save requested
//   save_block       out  index of the block to save
//   save_ack         in   HPS has copied save_block
//   dirty_any        out  any block dirty or a save outstanding
// ============================================================================
module nvram_backup_ctrl #(
  parameter int ADDR_W       = 13,
  parameter int BLOCK_W      = 9,
  parameter int QUIET_CYCLES = 3000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_cs,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic                      cpu_write_strobe,
  input  logic                      cpu_uds,
  input  logic [7:0]                cpu_din,
  output logic [15:0]               cpu_dout,
  output logic                      cpu_bus_ack,
  output logic                      cpu_changed,
  input  logic [ADDR_W-1:0]         hps_addr,
  input  logic [7:0]                hps_din,
  input  logic                      hps_wr,
  output logic [7:0]                hps_dout,
  input  logic                      restore_active,
  output logic                      save_req,
  output logic [ADDR_W-BLOCK_W-1:0] save_block,
  input  logic                      save_ack,
  output logic                      dirty_any
);

  localparam int NBLK_W = ADDR_W - BLOCK_W;
  localparam int NBLK   = 1 << NBLK_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TMR_W  = $clog2(QUIET_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(QUIET_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUIET = 2'd1,
    S_REQ   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // CPU access handshake
  // --------------------------------------------------------------------------
  logic r_armed;
  logic r_rd_pend;
  logic r_changed;
  logic r_restore_q;
  logic w_start;
  logic w_wr_acc;
  logic w_wr_commit;
  logic w_rd_acc;
  logic w_restore_fall;
  logic w_hps_we;

  // An armed access is only taken while no restore runs; the arm survives a
  // restore so a stalled access completes as soon as restore_active drops.
  assign w_start        = cpu_cs && r_armed && !restore_active;
  assign w_wr_acc       = w_start && cpu_write_strobe;
  assign w_wr_commit    = w_wr_acc && cpu_uds;
  assign w_rd_acc       = w_start && !cpu_write_strobe;
  assign w_restore_fall = r_restore_q && !restore_active;
  assign w_hps_we       = hps_wr && restore_active;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed     <= 1'b1;
      r_rd_pend   <= 1'b0;
      r_changed   <= 1'b0;
      r_restore_q <= 1'b0;
    end else begin
      // Re-arm only once cs has been seen low; one ack per cs assertion.
      if (!cpu_cs) begin
        r_armed <= 1'b1;
      end else if (w_start) begin
        r_armed <= 1'b0;
      end
      r_rd_pend   <= w_rd_acc;
      r_changed   <= w_wr_commit;
      r_restore_q <= restore_active;
    end
  end

  // Write ack is combinational, read ack follows the RAM read by one clock.
  assign cpu_bus_ack = w_wr_acc || r_rd_pend;
  assign cpu_changed = r_changed;

  // --------------------------------------------------------------------------
  // Byte RAM. CPU writes need !restore_active and HPS writes need
  // restore_active, so the two write ports never collide.
  // --------------------------------------------------------------------------
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_cpu_q;
  logic [7:0] r_hps_q;

  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      r_mem[cpu_addr] <= cpu_din;
    end else if (w_hps_we) begin
      r_mem[hps_addr] <= hps_din;
    end
  end

  // cpu_dout keeps the last read byte until the next read is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_q <= 8'h00;
    end else if (w_rd_acc) begin
      r_cpu_q <= r_mem[cpu_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hps_q <= 8'h00;
    end else begin
      r_hps_q <= r_mem[hps_addr];
    end
  end

  assign cpu_dout = {r_cpu_q, r_cpu_q};
  assign hps_dout = r_hps_q;

  // --------------------------------------------------------------------------
  // Dirty bitmap and quiet timer
  // --------------------------------------------------------------------------
  logic [NBLK-1:0]   r_dirty;
  logic [NBLK-1:0]   w_set;
  logic [NBLK-1:0]   w_clr;
  logic [NBLK-1:0]   w_dirty_nxt;
  logic [NBLK_W-1:0] w_low_idx;
  logic [TMR_W-1:0]  r_timer;
  logic              w_timer_zero;
  logic              w_reload;
  logic              w_capture;

  assign w_reload     = w_wr_commit || w_restore_fall;
  assign w_timer_zero = (r_timer == '0);

  // Lowest-index dirty block: scanning downwards leaves the lowest hit.
  always_comb begin
    w_low_idx = '0;
    for (int i = NBLK - 1; i >= 0; i--) begin
      if (r_dirty[i]) begin
        w_low_idx = NBLK_W'(i);
      end
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_wr_commit) begin
      w_set[cpu_addr[ADDR_W-1:BLOCK_W]] = 1'b1;
    end
    if (w_capture) begin
      w_clr[w_low_idx] = 1'b1;
    end
  end

  // Set is applied last so a write landing on the block being captured keeps
  // it dirty; the end of a restore wipes everything except such a new write.
  assign w_dirty_nxt = w_restore_fall ? w_set : ((r_dirty & ~w_clr) | w_set);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dirty <= '0;
      r_timer <= TMR_RELOAD;
    end else begin
      r_dirty <= w_dirty_nxt;
      // Free-running saturating countdown; only its zero state is consumed,
      // and only in QUIET, so counting in other states is harmless.
      if (w_reload) begin
        r_timer <= TMR_RELOAD;
      end else if (!w_timer_zero) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Save request FSM
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_dirty) begin
          w_state_nxt = S_QUIET;
        end
      end
      S_QUIET: begin
        if (!(|r_dirty)) begin
          w_state_nxt = S_IDLE;
        end else if (w_timer_zero && !restore_active) begin
          w_capture   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Passing through QUIET gives the one-cycle gap between requests;
        // with the timer already at zero it re-captures on the next clock.
        if (save_ack) begin
          w_state_nxt = (|r_dirty) ? S_QUIET : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      save_block <= '0;
    end else if (w_capture) begin
      save_block <= w_low_idx;
    end
  end

  assign save_req  = (r_state == S_REQ);
  assign dirty_any = (|r_dirty) || save_req;

endmodule
`default_nettype wire

// File: tb/tb_nvram_backup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nvram_backup_ctrl
// Description : Self-checking bench for nvram_backup_ctrl. A rule-based model
//               (edge counting, bitmaps, byte array) predicts every output on
//               every cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nvram_backup_ctrl;

  localparam int ADDR_W  = 13;
  localparam int BLOCK_W = 9;
  localparam int QUIET   = 10;
  localparam int NBLK_W  = ADDR_W - BLOCK_W;
  localparam int NBLK    = 1 << NBLK_W;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cpu_cs = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_write_strobe = 1'b0;
  logic              cpu_uds = 1'b0;
  logic [7:0]        cpu_din = '0;
  logic [15:0]       cpu_dout;
  logic              cpu_bus_ack;
  logic              cpu_changed;
  logic [ADDR_W-1:0] hps_addr = '0;
  logic [7:0]        hps_din = '0;
  logic              hps_wr = 1'b0;
  logic [7:0]        hps_dout;
  logic              restore_active = 1'b0;
  logic              save_req;
  logic [NBLK_W-1:0] save_block;
  logic              save_ack = 1'b0;
  logic              dirty_any;

  nvram_backup_ctrl #(
    .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .QUIET_CYCLES(QUIET)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_write_strobe(cpu_write_strobe),
    .cpu_uds(cpu_uds), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_bus_ack(cpu_bus_ack), .cpu_changed(cpu_changed),
    .hps_addr(hps_addr), .hps_din(hps_din), .hps_wr(hps_wr), .hps_dout(hps_dout),
    .restore_active(restore_active), .save_req(save_req),
    .save_block(save_block), .save_ack(save_ack), .dirty_any(dirty_any)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Edges are numbered from reset; the quiet timer is read
  // as "edges elapsed since the last reload edge". A request is raised at an
  // edge when nothing is outstanding, the dirty set is non-empty now and was
  // non-empty one edge earlier, QUIET edges have passed since the reload and
  // no restore runs.
  // --------------------------------------------------------------------------
  logic [7:0]      m_mem [DEPTH];
  bit              m_known [DEPTH];
  bit [NBLK-1:0]   m_dirty, m_dirty_prev;
  bit              m_req, m_armed, m_rd_pend, m_changed, m_restore_prev;
  int unsigned     m_blk;
  logic [7:0]      m_rd_byte, m_hps_byte;
  bit              m_rd_known, m_hps_known;
  longint          m_edge, m_reload_edge;

  always @(posedge clk or negedge reset_n) begin
    bit start, wr, rd, fall, capture, ack;
    bit [NBLK-1:0] set_v, clr_v;
    int low;
    if (!reset_n) begin
      m_dirty = '0; m_dirty_prev = '0; m_req = 0; m_armed = 1; m_rd_pend = 0;
      m_changed = 0; m_restore_prev = 0; m_blk = 0;
      m_rd_byte = 8'h00; m_rd_known = 1; m_hps_byte = 8'h00; m_hps_known = 1;
      m_edge = 0; m_reload_edge = 0;
    end else begin
      m_edge++;
      start = cpu_cs && m_armed && !restore_active;
      wr    = start && cpu_write_strobe && cpu_uds;
      rd    = start && !cpu_write_strobe;
      fall  = m_restore_prev && !restore_active;
      low = 0;
      while (low < NBLK - 1 && !m_dirty[low]) low++;
      capture = !m_req && (m_dirty_prev != 0) && (m_dirty != 0) &&
                (m_edge - 1 - m_reload_edge >= QUIET) && !restore_active;
      ack = m_req && save_ack;
      set_v = '0; clr_v = '0;
      if (wr) set_v[cpu_addr >> BLOCK_W] = 1'b1;
      if (capture) clr_v[low] = 1'b1;
      m_hps_byte  = m_mem[hps_addr];
      m_hps_known = m_known[hps_addr];
      if (rd) begin
        m_rd_byte  = m_mem[cpu_addr];
        m_rd_known = m_known[cpu_addr];
      end
      if (wr) begin
        m_mem[cpu_addr] = cpu_din; m_known[cpu_addr] = 1;
      end
      if (hps_wr && restore_active) begin
        m_mem[hps_addr] = hps_din; m_known[hps_addr] = 1;
      end
      m_dirty_prev = m_dirty;
      m_dirty = fall ? set_v : ((m_dirty & ~clr_v) | set_v);
      if (wr || fall) m_reload_edge = m_edge;
      if (capture) begin
        m_req = 1; m_blk = low;
      end else if (ack) begin
        m_req = 0;
      end
      if (!cpu_cs) m_armed = 1;
      else if (start) m_armed = 0;
      m_rd_pend = rd;
      m_changed = wr;
      m_restore_prev = restore_active;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      check("ack", cpu_bus_ack,
            (cpu_cs && m_armed && !restore_active && cpu_write_strobe) || m_rd_pend);
      check("changed", cpu_changed, m_changed);
      check("save_req", save_req, m_req);
      check("save_block", save_block, m_blk);
      check("dirty_any", dirty_any, (m_dirty != 0) || m_req);
      if (m_rd_known) check("cpu_dout", cpu_dout, {m_rd_byte, m_rd_byte});
      if (m_hps_known) check("hps_dout", hps_dout, m_hps_byte);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called just after a rising edge unless noted)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit u);
    cpu_cs = 1; cpu_write_strobe = 1; cpu_uds = u; cpu_addr = a; cpu_din = d;
    tick();
    cpu_cs = 0; cpu_write_strobe = 0; cpu_uds = 0;
  endtask

  // Returns at a falling edge with save_req high; n = edges since the edge
  // that ended the caller's last cycle (0 = the first observed cycle).
  task automatic wait_req(input string name, output int n);
    n = -1;
    for (int j = 0; j <= 60; j++) begin
      @(negedge clk);
      if (save_req) begin
        n = j;
        break;
      end
    end
    if (n < 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: save_req timeout", name);
    end
  endtask

  // Called at a falling edge: acknowledge for one edge.
  task automatic ack_req();
    save_ack = 1;
    tick();
    save_ack = 0;
  endtask

  logic [ADDR_W-1:0] pool [16];

  initial begin
    int n, acks, gap, rcnt;
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst save_req", save_req, 0);
    check("rst dirty_any", dirty_any, 0);
    check("rst cpu_dout", cpu_dout, 0);
    check("rst ack", cpu_bus_ack, 0);
    check("rst hps_dout", hps_dout, 0);
    @(posedge clk); #1; reset_n = 1;
    tick();

    // ---------------- test 1: write / read ----------------
    cpu_cs = 1; cpu_write_strobe = 1; cpu_uds = 1; cpu_addr = 13'h0123; cpu_din = 8'hA5;
    @(negedge clk);
    check("t1 wr ack same cycle", cpu_bus_ack, 1);
    tick();
    cpu_cs = 0; cpu_write_strobe = 0; cpu_uds = 0;
    @(negedge clk);
    check("t1 changed pulse", cpu_changed, 1);
    tick();
    cpu_cs = 1; cpu_addr = 13'h0123; acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check("t1 rd no ack cyc1", cpu_bus_ack, 0);
      if (i == 1) begin
        check("t1 rd ack cyc2", cpu_bus_ack, 1);
        check("t1 rd data", cpu_dout, 16'hA5A5);
      end
      acks += int'(cpu_bus_ack);
      tick();
    end
    check("t1 single ack", acks, 1);
    cpu_cs = 0;
    wait_req("t1 flush", n);
    check("t1 flush block", save_block, 0);
    ack_req();

    // ---------------- test 2: quiet timer and block order ----------------
    cpu_write(13'h0600, 8'h33, 1);
    tick();
    cpu_write(13'h0200, 8'h44, 1);
    wait_req("t2 req", n);
    check("t2 latency", n, QUIET + 1);
    check("t2 first block", save_block, 1);
    ack_req();
    @(negedge clk);
    check("t2 gap", save_req, 0);
    tick();
    @(negedge clk);
    check("t2 second req", save_req, 1);
    check("t2 second block", save_block, 3);
    ack_req();
    @(negedge clk);
    check("t2 clean", dirty_any, 0);
    tick();

    // ---------------- test 3: write during save ----------------
    cpu_write(13'h02A0, 8'h11, 1);
    wait_req("t3 req a", n);
    check("t3 block a", save_block, 1);
    tick();
    cpu_write(13'h02A1, 8'h22, 1);
    @(negedge clk);
    ack_req();
    wait_req("t3 req b", n);
    check("t3 block b", save_block, 1);
    ack_req();
    @(negedge clk);
    check("t3 clean b", dirty_any, 0);
    tick();
    cpu_write(13'h0210, 8'h55, 1);
    repeat (QUIET) tick();
    cpu_write(13'h0211, 8'h66, 1);      // lands on the capture edge
    @(negedge clk);
    check("t3 capture req", save_req, 1);
    check("t3 capture block", save_block, 1);
    ack_req();
    @(negedge clk);
    check("t3 stays dirty", dirty_any, 1);
    wait_req("t3 req c", n);
    check("t3 block c", save_block, 1);
    ack_req();
    @(negedge clk);
    check("t3 clean c", dirty_any, 0);
    tick();

    // ---------------- test 4: restore ----------------
    restore_active = 1;
    tick();
    hps_wr = 1; hps_addr = 13'h0010; hps_din = 8'h5A;
    tick();
    hps_wr = 0;
    @(negedge clk);
    check("t4 no dirty", dirty_any, 0);
    tick();
    cpu_cs = 1; cpu_write_strobe = 0; cpu_addr = 13'h0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4 stalled", cpu_bus_ack, 0);
      tick();
    end
    check("t4 hps_dout", hps_dout, 8'h5A);
    restore_active = 0;
    @(negedge clk);
    check("t4 ack cyc1", cpu_bus_ack, 0);
    tick();
    @(negedge clk);
    check("t4 ack cyc2", cpu_bus_ack, 1);
    check("t4 data", cpu_dout, 16'h5A5A);
    tick();
    cpu_cs = 0;
    tick();

    // ---------------- test 5: uds=0 and reset ----------------
    cpu_cs = 1; cpu_write_strobe = 1; cpu_uds = 0; cpu_addr = 13'h0123; cpu_din = 8'h00;
    @(negedge clk);
    check("t5 uds0 ack", cpu_bus_ack, 1);
    tick();
    cpu_cs = 0; cpu_write_strobe = 0;
    @(negedge clk);
    check("t5 uds0 no change", cpu_changed, 0);
    check("t5 uds0 no dirty", dirty_any, 0);
    tick();
    cpu_cs = 1; cpu_addr = 13'h0123;
    tick();
    @(negedge clk);
    check("t5 ram kept", cpu_dout, 16'hA5A5);
    tick();
    cpu_cs = 0;
    tick();
    cpu_write(13'h0A00, 8'h77, 1);
    wait_req("t5 req", n);
    #2 reset_n = 0;
    #1 check("t5 async drop", save_req, 0);
    tick();
    tick();
    reset_n = 1;
    @(negedge clk);
    check("t5 dirty after reset", dirty_any, 0);
    tick();

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 16; i++) pool[i] = ADDR_W'((i << BLOCK_W) | ($urandom & 32'h1FF));
    gap = 0; rcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (cpu_cs) begin
        if ($urandom_range(0, 2) == 0) cpu_cs = 0;
      end else if (gap > 0) begin
        gap--;
      end else begin
        cpu_cs = 1;
        cpu_write_strobe = $urandom_range(0, 1) == 1;
        cpu_uds = $urandom_range(0, 3) != 0;
        cpu_addr = pool[$urandom_range(0, 15)];
        cpu_din = 8'($urandom);
        gap = $urandom_range(0, 25);
      end
      if (restore_active) begin
        rcnt--;
        if (rcnt <= 0) restore_active = 0;
      end else if ($urandom_range(0, 299) == 0) begin
        restore_active = 1;
        rcnt = $urandom_range(2, 15);
      end
      hps_wr = $urandom_range(0, 1) == 1;
      hps_addr = pool[$urandom_range(0, 15)];
      hps_din = 8'($urandom);
      save_ack = $urandom_range(0, 2) == 0;
      tick();
    end
    cpu_cs = 0; restore_active = 0; hps_wr = 0; save_ack = 0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
